// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
// Pure declarations; no logic and no timing.
package prog_loader_pkg;

  localparam int BYTE_BITS  = 8;
  localparam int COUNT_BITS = 16;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/loader_timer.sv
// Clearable saturating inter-byte timeout counter; expired is decoded from the count register.
// No flow control: clr wins over inc, and the count holds once LIMIT is reached.
module loader_timer #(
  parameter int LIMIT = 1_000_000,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] cnt_q;

  assign expired = (cnt_q >= W'(LIMIT));

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// UART-fed program loader: writes N 16-bit words to program memory, then releases the CPU reset.
// One write cycle per word; the optional inter-byte timeout is enabled by PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int ADDR_LENGTH    = 11,
  parameter int DATA_LENGTH    = 16,
  parameter int BYTE_BITS      = prog_loader_pkg::BYTE_BITS,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [BYTE_BITS-1:0]   i_rx_data,
  input  logic                   i_rx_done,
  output logic                   o_Wr,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic [DATA_LENGTH-1:0] o_Data,
  output logic                   o_cpu_reset,
  output logic                   o_done,
  output logic                   o_error
);

  import prog_loader_pkg::*;

  localparam int DEPTH = 1 << ADDR_LENGTH;

  state_t                 state_q, state_d;
  logic [COUNT_BITS-1:0]  remain_q, remain_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [COUNT_BITS-1:0]  count_full;
  logic                   timed_out;

`ifdef PROG_LOADER_TIMEOUT_EN
  logic tmr_inc;

  assign tmr_inc = (state_q == CNT_LO) || (state_q == DATA_HI) || (state_q == DATA_LO);

  loader_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .core_clk (i_clock),
    .arst_n   (i_reset),
    .clr      (i_rx_done),
    .inc      (tmr_inc),
    .expired  (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // The high count byte is parked in the remaining counter until the low byte arrives.
  assign count_full = {remain_q[COUNT_BITS-1 -: BYTE_BITS], i_rx_data};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= CNT_HI;
      remain_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      CNT_HI: begin
        if (i_rx_done) begin
          remain_d[COUNT_BITS-1 -: BYTE_BITS] = i_rx_data;
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (i_rx_done) begin
          remain_d = count_full;
          if (count_full == '0)
            state_d = DONE;
          else if (int'(count_full) > DEPTH)
            state_d = ERR;
          else
            state_d = DATA_HI;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      DATA_HI: begin
        if (i_rx_done) begin
          data_d[DATA_LENGTH-1 -: BYTE_BITS] = i_rx_data;
          state_d = DATA_LO;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      DATA_LO: begin
        if (i_rx_done) begin
          data_d[BYTE_BITS-1:0] = i_rx_data;
          state_d = WRITE;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      WRITE: begin
        // Address wraps to 0 after a full-depth load; nothing reads it afterwards.
        addr_d   = addr_q + ADDR_LENGTH'(1);
        remain_d = remain_q - COUNT_BITS'(1);
        if (remain_q == COUNT_BITS'(1)) begin
          state_d = DONE;
        end else if (i_rx_done) begin
          data_d[DATA_LENGTH-1 -: BYTE_BITS] = i_rx_data;
          state_d = DATA_LO;
        end else begin
          state_d = DATA_HI;
        end
      end
      DONE, ERR: ;
      default: state_d = CNT_HI;
    endcase
  end

  assign o_Wr        = (state_q == WRITE);
  assign o_Addr      = addr_q;
  assign o_Data      = data_q;
  assign o_cpu_reset = (state_q != DONE);
  assign o_done      = (state_q == DONE);
  assign o_error     = (state_q == ERR);

endmodule
